hazard_sb: RTL and testbench
============================

Name: hazard_sb

Overview:
- Parametrised load-use stall unit for the decode stage.
- Compares decode-stage source and target register indices, across NUM_RF register files, against load destinations in flight in NUM_STAGES post-decode pipeline stages.
- Asserts a registered multi-cycle stall until each matching load reaches writeback.
- Adds per-operand read enables, flush, hold/freeze, a running re-evaluation during stalls, a hazard-stage report, and a saturating stall-cycle statistic.

Parameters:
- NUM_STAGES, 3: post-decode stages tracked. Stage 0 is youngest (EX/MA); stage NUM_STAGES-1 is oldest (MO/WB). Must be >=1.
- NUM_RF, 2: register files compared. Index 0 is GP, index 1 is SR.
- ADDR_W, 4: register index width per file.
- STAT_W, 16: width of the stall-cycle statistic counter.
- CNT_W, $clog2(NUM_STAGES+1): derived stall counter width; not overridden.

Ports:
- iw_clk  in  1  clock
- iw_rst_n  in  1  asynchronous active-low reset
- iw_flush  in  1  pipeline flush; cancels any stall
- iw_hold  in  1  global freeze (e.g. memory wait); all state holds
- iw_stat_clr  in  1  synchronous clear of ow_stall_total
- iw_stg_ld  in  NUM_STAGES*NUM_RF  bit s*NUM_RF+r: stage s holds a load writing file r with write enable set
- iw_stg_tgt  in  NUM_STAGES*NUM_RF*ADDR_W  slice (s*NUM_RF+r): load destination index for stage s, file r
- iw_dec_valid  in  1  decode stage holds a valid instruction
- iw_dec_src  in  NUM_RF*ADDR_W  decode source index per file
- iw_dec_src_re  in  NUM_RF  source actually read, per file
- iw_dec_tgt  in  NUM_RF*ADDR_W  decode target index per file; read-modify-write operand
- iw_dec_tgt_re  in  NUM_RF  target actually read, per file
- ow_stall  out  1  stall decode and earlier stages
- ow_stall_cnt  out  CNT_W  remaining stall cycles
- ow_hz_stage  out  NUM_STAGES  mask of stages that matched at the last update
- ow_stall_total  out  STAT_W  saturating count of stall cycles

Behaviour:
- Reset: async on iw_rst_n low. Internal counter, ow_stall_cnt, ow_hz_stage and ow_stall_total all go to 0 immediately; ow_stall goes to 0. This applies mid-stall too.
- Match (combinational), per stage s and file r:
  - m[s][r] = iw_dec_valid & iw_stg_ld[s,r] & ((iw_dec_src_re[r] & src[r]==tgt[s,r]) | (iw_dec_tgt_re[r] & dectgt[r]==tgt[s,r])).
  - hz[s] = OR over r of m[s][r].
- Required count: req = max over s with hz[s] of (NUM_STAGES - s), else 0. Stage 0 gives NUM_STAGES; oldest stage gives 1.
- Counter update on rising edge, in priority order:
  - flush: cnt <= 0, ow_hz_stage <= 0.
  - hold: cnt, ow_hz_stage and stats unchanged; iw_stat_clr is still honoured.
  - otherwise: cnt <= max(cnt==0 ? 0 : cnt-1, req); ow_hz_stage <= hz.
- Re-evaluation runs every non-hold cycle, including while stalling. A deeper newly-visible hazard extends the stall. It never shortens a running one.
- ow_stall = (cnt != 0). It is registered, so it asserts the cycle after detection. ow_stall_cnt = cnt.
- Statistic:
  - iw_stat_clr: total <= 0. Highest priority below reset; applies even under hold or flush.
  - Otherwise, if !iw_hold and cnt != 0 and !iw_flush: total <= total+1, saturating at all-ones (no wrap).
- Equal indices in different files never match each other; comparisons are strictly per file.
- iw_dec_valid=0 forces req=0; any running count still decrements.
- With NUM_STAGES=1, cnt is 1 bit and any match gives a one-cycle stall.

Test Plan (NUM_STAGES=3, NUM_RF=2, ADDR_W=4 unless stated):
- Stage 0 file 0 load tgt 5; dec src0=5, src_re0=1, valid=1, pulsed one cycle -> next cycle cnt=3, ow_stall high exactly 3 cycles (cnt 3,2,1), ow_hz_stage=001 at first, ow_stall_total=3.
- Same stimulus with src_re0=0, tgt_re0=0, or with the load tagged file 1 (same index 5) -> ow_stall never asserts, total stays 0.
- Stage 2 file 1 tgt 7 matches dec tgt1=7 (tgt_re1=1) while stage 0 file 0 tgt 2 matches src0=2 -> cnt=3 (max), ow_hz_stage=101. Stage 2 match alone -> cnt=1.
- Stall running at cnt=2; new match in stage 0 appears -> cnt reloads 3, not 1. Then iw_hold high 2 cycles -> cnt stays 3 and total unchanged; release -> cnt 2,1,0.
- cnt=3 with a concurrent new hazard, iw_flush pulsed -> cnt=0 and ow_hz_stage=0 next edge, no total increment. iw_rst_n low mid-stall at cnt=2 -> ow_stall, cnt and total drop to 0 asynchronously, before the next edge.
- STAT_W=2, 5 stall cycles -> total reads 1,2,3,3,3. iw_stat_clr -> 0 next edge, even with iw_hold=1.

Source files
------------

// File: rtl/hazard_sb.sv
// Load-use stall unit for decode: matches decode operands against in-flight load
// destinations and holds a registered, self-extending stall until they reach writeback.
module hazard_sb #(
  parameter  int NUM_STAGES = 3,
  parameter  int NUM_RF     = 2,
  parameter  int ADDR_W     = 4,
  parameter  int STAT_W     = 16,
  localparam int CNT_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                                iw_clk,
  input  logic                                iw_rst_n,
  input  logic                                iw_flush,
  input  logic                                iw_hold,
  input  logic                                iw_stat_clr,
  input  logic [NUM_STAGES*NUM_RF-1:0]        iw_stg_ld,
  input  logic [NUM_STAGES*NUM_RF*ADDR_W-1:0] iw_stg_tgt,
  input  logic                                iw_dec_valid,
  input  logic [NUM_RF*ADDR_W-1:0]            iw_dec_src,
  input  logic [NUM_RF-1:0]                   iw_dec_src_re,
  input  logic [NUM_RF*ADDR_W-1:0]            iw_dec_tgt,
  input  logic [NUM_RF-1:0]                   iw_dec_tgt_re,
  output logic                                ow_stall,
  output logic [CNT_W-1:0]                    ow_stall_cnt,
  output logic [NUM_STAGES-1:0]               ow_hz_stage,
  output logic [STAT_W-1:0]                   ow_stall_total
);

  logic [NUM_STAGES-1:0] hz;
  logic [CNT_W-1:0]      req;
  logic [CNT_W-1:0]      cnt, cnt_dec, cnt_nxt;
  logic                  stall_q;
  logic [NUM_STAGES-1:0] hz_q;
  logic [STAT_W-1:0]     total_q;

  // Per-stage hazard mask and the deepest stall it demands. Scanning oldest to
  // youngest lets the youngest matching stage (longest wait) win.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write so no latch is inferred.
    hz  = '0;
    req = '0;
    for (int s = NUM_STAGES - 1; s >= 0; s--) begin
      for (int r = 0; r < NUM_RF; r++) begin
        if (iw_dec_valid && iw_stg_ld[s*NUM_RF + r] &&
            ((iw_dec_src_re[r] &&
              iw_dec_src[r*ADDR_W +: ADDR_W] == iw_stg_tgt[(s*NUM_RF + r)*ADDR_W +: ADDR_W]) ||
             (iw_dec_tgt_re[r] &&
              iw_dec_tgt[r*ADDR_W +: ADDR_W] == iw_stg_tgt[(s*NUM_RF + r)*ADDR_W +: ADDR_W])))
          hz[s] = 1'b1;
      end
      if (hz[s]) req = CNT_W'(NUM_STAGES - s);
    end
  end

  // A running stall only ever gets extended by a new hazard, never shortened.
  always_comb begin
    cnt_dec = (cnt == '0) ? '0 : cnt - 1'b1;
    if (iw_flush)     cnt_nxt = '0;
    else if (iw_hold) cnt_nxt = cnt;
    else              cnt_nxt = (cnt_dec > req) ? cnt_dec : req;
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      cnt     <= '0;
      stall_q <= 1'b0;
      hz_q    <= '0;
      total_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      cnt     <= cnt_nxt;
      stall_q <= (cnt_nxt != '0);
      if (iw_flush)     hz_q <= '0;
      else if (!iw_hold) hz_q <= hz;
      // Statistic clear overrides hold and flush; the count saturates instead of wrapping.
      if (iw_stat_clr)
        total_q <= '0;
      else if (!iw_hold && !iw_flush && cnt != '0 && total_q != '1)
        total_q <= total_q + 1'b1;
    end
  end

  assign ow_stall       = stall_q;
  assign ow_stall_cnt   = cnt;
  assign ow_hz_stage    = hz_q;
  assign ow_stall_total = total_q;

endmodule

// File: tb/tb_hazard_sb.sv
// Directed bench for hazard_sb: default instance plus a 2-bit statistic instance
// sharing the same stimulus for the saturation check.
module tb_hazard_sb;
  localparam int NS = 3;
  localparam int NR = 2;
  localparam int AW = 4;
  localparam int CW = $clog2(NS + 1);

  logic              iw_clk = 1'b0;
  logic              iw_rst_n;
  logic              iw_flush, iw_hold, iw_stat_clr;
  logic [NS*NR-1:0]    iw_stg_ld;
  logic [NS*NR*AW-1:0] iw_stg_tgt;
  logic              iw_dec_valid;
  logic [NR*AW-1:0]  iw_dec_src, iw_dec_tgt;
  logic [NR-1:0]     iw_dec_src_re, iw_dec_tgt_re;

  logic              ow_stall, sat_stall;
  logic [CW-1:0]     ow_stall_cnt, sat_stall_cnt;
  logic [NS-1:0]     ow_hz_stage, sat_hz_stage;
  logic [15:0]       ow_stall_total;
  logic [1:0]        sat_stall_total;

  int vectors = 0;
  int miscompares = 0;

  always #5 iw_clk = ~iw_clk;

  hazard_sb #(.NUM_STAGES(NS), .NUM_RF(NR), .ADDR_W(AW), .STAT_W(16)) u_dut (
    .iw_clk(iw_clk), .iw_rst_n(iw_rst_n), .iw_flush(iw_flush), .iw_hold(iw_hold),
    .iw_stat_clr(iw_stat_clr), .iw_stg_ld(iw_stg_ld), .iw_stg_tgt(iw_stg_tgt),
    .iw_dec_valid(iw_dec_valid), .iw_dec_src(iw_dec_src), .iw_dec_src_re(iw_dec_src_re),
    .iw_dec_tgt(iw_dec_tgt), .iw_dec_tgt_re(iw_dec_tgt_re),
    .ow_stall(ow_stall), .ow_stall_cnt(ow_stall_cnt), .ow_hz_stage(ow_hz_stage),
    .ow_stall_total(ow_stall_total)
  );

  hazard_sb #(.NUM_STAGES(NS), .NUM_RF(NR), .ADDR_W(AW), .STAT_W(2)) u_sat (
    .iw_clk(iw_clk), .iw_rst_n(iw_rst_n), .iw_flush(iw_flush), .iw_hold(iw_hold),
    .iw_stat_clr(iw_stat_clr), .iw_stg_ld(iw_stg_ld), .iw_stg_tgt(iw_stg_tgt),
    .iw_dec_valid(iw_dec_valid), .iw_dec_src(iw_dec_src), .iw_dec_src_re(iw_dec_src_re),
    .iw_dec_tgt(iw_dec_tgt), .iw_dec_tgt_re(iw_dec_tgt_re),
    .ow_stall(sat_stall), .ow_stall_cnt(sat_stall_cnt), .ow_hz_stage(sat_hz_stage),
    .ow_stall_total(sat_stall_total)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks stall, count, hazard mask and total of the default instance in one go.
  task automatic check_st(input string tag, input logic stall, input int cnt,
                          input logic [NS-1:0] hzm, input int total);
    check({tag, ".stall"}, 32'(ow_stall), 32'(stall));
    check({tag, ".cnt"},   32'(ow_stall_cnt), 32'(cnt));
    check({tag, ".hz"},    32'(ow_hz_stage), 32'(hzm));
    check({tag, ".total"}, 32'(ow_stall_total), 32'(total));
  endtask

  task automatic step();
    @(posedge iw_clk);
    @(negedge iw_clk);
  endtask

  task automatic clr_in();
    iw_flush = 0; iw_hold = 0; iw_stat_clr = 0;
    iw_stg_ld = '0; iw_stg_tgt = '0; iw_dec_valid = 0;
    iw_dec_src = '0; iw_dec_tgt = '0; iw_dec_src_re = '0; iw_dec_tgt_re = '0;
  endtask

  task automatic set_ld(input int s, input int r, input logic [AW-1:0] t);
    iw_stg_ld[s*NR + r] = 1'b1;
    iw_stg_tgt[(s*NR + r)*AW +: AW] = t;
  endtask

  task automatic set_src(input int r, input logic [AW-1:0] idx, input logic re);
    iw_dec_src[r*AW +: AW] = idx;
    iw_dec_src_re[r] = re;
  endtask

  task automatic set_tgt(input int r, input logic [AW-1:0] idx, input logic re);
    iw_dec_tgt[r*AW +: AW] = idx;
    iw_dec_tgt_re[r] = re;
  endtask

  task automatic stat_clear();
    iw_stat_clr = 1; step(); iw_stat_clr = 0;
  endtask

  initial begin
    clr_in();
    iw_rst_n = 0;
    step(); step();
    check_st("reset", 0, 0, 3'b000, 0);
    iw_rst_n = 1;
    step();

    // Stage 0 file 0 load to r5, decode reads r5: three-cycle stall.
    set_ld(0, 0, 4'd5); set_src(0, 4'd5, 1); iw_dec_valid = 1;
    step();
    iw_dec_valid = 0;
    check_st("s0_hit", 1, 3, 3'b001, 0);
    step(); check_st("s0_cnt2", 1, 2, 3'b000, 1);
    step(); check_st("s0_cnt1", 1, 1, 3'b000, 2);
    step(); check_st("s0_done", 0, 0, 3'b000, 3);
    step(); check_st("s0_idle", 0, 0, 3'b000, 3);
    stat_clear();
    check("stat_clr", 32'(ow_stall_total), 32'd0);

    // Read enables off: same indices never match.
    clr_in(); set_ld(0, 0, 4'd5); set_src(0, 4'd5, 0); set_tgt(0, 4'd5, 0); iw_dec_valid = 1;
    step(); check_st("no_re", 0, 0, 3'b000, 0);
    // Target read enable alone is enough to match.
    set_tgt(0, 4'd5, 1);
    step(); check_st("tgt_re", 1, 3, 3'b001, 0);
    iw_dec_valid = 0; step(); step(); step(); stat_clear();
    // Load in file 1 never matches a file 0 operand with the same index.
    clr_in(); set_ld(0, 1, 4'd5); set_src(0, 4'd5, 1); set_src(1, 4'd9, 1); iw_dec_valid = 1;
    step(); check_st("xfile", 0, 0, 3'b000, 0);
    step(); check("xfile_total", 32'(ow_stall_total), 32'd0);

    // Stage 2 file 1 via target plus stage 0 file 0 via source: max wins.
    clr_in(); set_ld(2, 1, 4'd7); set_tgt(1, 4'd7, 1); set_ld(0, 0, 4'd2); set_src(0, 4'd2, 1);
    iw_dec_valid = 1;
    step(); check("multi_cnt", 32'(ow_stall_cnt), 32'd3);
    check("multi_hz", 32'(ow_hz_stage), 32'b101);
    iw_dec_valid = 0; step(); step(); step();
    check("multi_drain", 32'(ow_stall_cnt), 32'd0);
    clr_in(); set_ld(2, 1, 4'd7); set_tgt(1, 4'd7, 1); iw_dec_valid = 1;
    step(); check("s2_cnt", 32'(ow_stall_cnt), 32'd1);
    check("s2_hz", 32'(ow_hz_stage), 32'b100);
    iw_dec_valid = 0; step();
    check("s2_done", 32'(ow_stall), 32'd0);
    stat_clear();

    // Running stall at 2 reloads to 3 on a younger hazard, then freezes under hold.
    clr_in(); set_ld(1, 0, 4'd4); set_src(0, 4'd4, 1); iw_dec_valid = 1;
    step(); check_st("ext_s1", 1, 2, 3'b010, 0);
    clr_in(); set_ld(0, 0, 4'd4); set_src(0, 4'd4, 1); iw_dec_valid = 1;
    step(); check_st("ext_reload", 1, 3, 3'b001, 1);
    iw_dec_valid = 0; iw_hold = 1;
    step(); check_st("hold1", 1, 3, 3'b001, 1);
    step(); check_st("hold2", 1, 3, 3'b001, 1);
    // Releasing with a shallow stage 2 hazard present must not shorten the stall.
    iw_hold = 0; clr_in(); set_ld(2, 1, 4'd7); set_tgt(1, 4'd7, 1); iw_dec_valid = 1;
    step(); check_st("rel_cnt2", 1, 2, 3'b100, 2);
    iw_dec_valid = 0;
    step(); check_st("rel_cnt1", 1, 1, 3'b000, 3);
    step(); check_st("rel_cnt0", 0, 0, 3'b000, 4);
    stat_clear();

    // Flush with a concurrent hazard cancels everything, no statistic bump.
    clr_in(); set_ld(0, 0, 4'd3); set_src(0, 4'd3, 1); iw_dec_valid = 1;
    step(); check_st("pre_flush", 1, 3, 3'b001, 0);
    iw_flush = 1;
    step(); check_st("flush", 0, 0, 3'b000, 0);
    iw_flush = 0; iw_dec_valid = 0;

    // Asynchronous reset mid-stall clears outputs before the next edge.
    iw_dec_valid = 1; step(); iw_dec_valid = 0;
    step(); check_st("pre_rst", 1, 2, 3'b000, 1);
    #2 iw_rst_n = 0;
    #1 check_st("async_rst", 0, 0, 3'b000, 0);
    @(negedge iw_clk); iw_rst_n = 1;
    clr_in(); step();

    // Two-bit statistic saturates at 3 over five stall cycles.
    set_ld(0, 0, 4'd6); set_src(0, 4'd6, 1); iw_dec_valid = 1;
    step(); check("sat_first", 32'(sat_stall_total), 32'd0);
    step(); check("sat_t1", 32'(sat_stall_total), 32'd1);
    step(); check("sat_t2", 32'(sat_stall_total), 32'd2);
    step(); check("sat_t3", 32'(sat_stall_total), 32'd3);
    iw_dec_valid = 0;
    step(); check("sat_t4", 32'(sat_stall_total), 32'd3);
    step(); check("sat_t5", 32'(sat_stall_total), 32'd3);
    check("full_t5", 32'(ow_stall_total), 32'd5);
    step(); check("sat_idle", 32'(sat_stall_total), 32'd3);
    check("sat_stall_off", 32'(sat_stall), 32'd0);
    iw_hold = 1; iw_stat_clr = 1;
    step(); check("sat_clr_hold", 32'(sat_stall_total), 32'd0);
    check("full_clr_hold", 32'(ow_stall_total), 32'd0);
    iw_hold = 0; iw_stat_clr = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
